prbs_word_checker: RTL

- Receive-side counterpart of the team's 16-bit LFSR word generator.
- Consumes a stream of 16-bit words that should follow the generator's sequence, self-synchronises to it and reports lock status.
- Counts and flags sequence errors.
- Sits at the sink end of any datapath exercised with PRBS traffic (loopback, FIFO, link soak tests).

---
 rtl/prbs_word_checker_pkg.sv | 16 +
 rtl/prbs_word_checker_if.sv | 28 ++
 rtl/prbs_word_checker_sat_counter.sv | 19 +
 rtl/prbs_word_checker.sv | 82 ++++++++
 4 files changed

// File: rtl/prbs_word_checker_pkg.sv
// prbs_word_checker_pkg: shared LFSR definitions for the 16-bit PRBS generator and checker.
package prbs_pkg;
    localparam int PRBS_W = 16;
    localparam logic [PRBS_W-1:0] PRBS_TAPS = 16'h9021;
    localparam logic [PRBS_W-1:0] PRBS_RST_SEED = 16'h0F0F;
    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} chk_state_t;
    function automatic logic [PRBS_W-1:0] prbs_next(input logic [PRBS_W-1:0] w);
        return {w[PRBS_W-2:0], ^(w & PRBS_TAPS)};
    endfunction
    function automatic logic [4:0] popcount16(input logic [15:0] x);
        logic [4:0] s;
        s = '0;
        for (int i = 0; i < 16; i++) s = s + {4'd0, x[i]};
        return s;
    endfunction
endpackage

// File: rtl/prbs_word_checker_if.sv
// prbs_word_checker_if: word stream in, lock/error status out.
// bit_err_count exists only when PRBS_WORD_CHECKER_BITERR_EN is defined.
interface prbs_word_checker_if #(parameter int CNT_W = 16);
    logic in_valid;
    logic [15:0] in_data;
    logic clr_cnt;
    logic locked;
    logic err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] word_count;
`ifdef PRBS_WORD_CHECKER_BITERR_EN
    logic [CNT_W+3:0] bit_err_count;
`endif
    modport master (
        output in_valid, in_data, clr_cnt,
`ifdef PRBS_WORD_CHECKER_BITERR_EN
        input bit_err_count,
`endif
        input locked, err_pulse, err_count, word_count
    );
    modport slave (
        input in_valid, in_data, clr_cnt,
`ifdef PRBS_WORD_CHECKER_BITERR_EN
        output bit_err_count,
`endif
        output locked, err_pulse, err_count, word_count
    );
endinterface

// File: rtl/prbs_word_checker_sat_counter.sv
// sat_counter: accumulator that sticks at all-ones, with synchronous clear taking priority.
module sat_counter #(
    parameter int W = 16,
    parameter int IW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [IW-1:0] inc,
    output logic [W-1:0]  cnt
);
    logic [W:0] sum;
    assign sum = {1'b0, cnt} + {{(W + 1 - IW){1'b0}}, inc};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else cnt <= sum[W] ? '1 : sum[W-1:0];
    end
endmodule

// File: rtl/prbs_word_checker.sv
// prbs_word_checker: self-synchronising checker for the 16-bit PRBS word stream.
// Define PRBS_WORD_CHECKER_BITERR_EN to add the bit_err_count accumulator.
module prbs_word_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst_n,
    prbs_word_checker_if.slave bus
);
    chk_state_t state, state_n;
    logic [15:0] pred, pred_n;
    logic [3:0] match_cnt, match_n, miss_cnt, miss_n;
    logic mismatch, acc_locked;
    assign mismatch = bus.in_data != pred;
    assign acc_locked = bus.in_valid && state == LOCKED;
    always_comb begin
        state_n = state;
        pred_n = pred;
        match_n = match_cnt;
        miss_n = miss_cnt;
        if (bus.in_valid) begin
            if (state == LOCKED) begin
                // free-run the prediction so a lone corrupted word cannot derail tracking
                pred_n = prbs_next(pred);
                miss_n = mismatch ? miss_cnt + 4'd1 : 4'd0;
                if (miss_n == 4'(UNLOCK_CNT)) begin
                    state_n = SEARCH;
                    miss_n = '0;
                end
            end else if (state == VERIFY && !mismatch) begin
                pred_n = prbs_next(bus.in_data);
                match_n = match_cnt + 4'd1;
                if (match_n == 4'(LOCK_CNT)) begin
                    state_n = LOCKED;
                    miss_n = '0;
                end
            end else if (bus.in_data == '0) begin
                state_n = SEARCH;
            end else begin
                state_n = VERIFY;
                pred_n = prbs_next(bus.in_data);
                match_n = '0;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEARCH;
            pred <= '0;
            match_cnt <= '0;
            miss_cnt <= '0;
            bus.err_pulse <= 1'b0;
        end else begin
            state <= state_n;
            pred <= pred_n;
            match_cnt <= match_n;
            miss_cnt <= miss_n;
            bus.err_pulse <= acc_locked && mismatch;
        end
    end
    assign bus.locked = state == LOCKED;
    sat_counter #(.W(CNT_W), .IW(1)) u_err_cnt (
        .clk(clk), .rst_n(rst_n), .clr(bus.clr_cnt),
        .inc(acc_locked && mismatch), .cnt(bus.err_count)
    );
    sat_counter #(.W(CNT_W), .IW(1)) u_word_cnt (
        .clk(clk), .rst_n(rst_n), .clr(bus.clr_cnt),
        .inc(acc_locked), .cnt(bus.word_count)
    );
`ifdef PRBS_WORD_CHECKER_BITERR_EN
    logic [4:0] bit_errs;
    assign bit_errs = acc_locked ? popcount16(bus.in_data ^ pred) : 5'd0;
    sat_counter #(.W(CNT_W + 4), .IW(5)) u_bit_cnt (
        .clk(clk), .rst_n(rst_n), .clr(bus.clr_cnt),
        .inc(bit_errs), .cnt(bus.bit_err_count)
    );
`endif
endmodule
